apb_master_ctrl: RTL

Single-outstanding APB4 requester that sequences one APB transfer per accepted request. It turns a valid/ready request channel and a valid/ready response channel into the APB SETUP/ACCESS protocol, and guards each transfer with a bounded-wait timeout. It sits between an internal agent (debug module, DMA-style engine) and an APB master port, which is typically one input of the two-master APB arbiter.

---
 rtl/apb_master_ctrl_if.sv | 44 ++++
 rtl/apb_master_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl_if.sv
// APB4 bus bundle between a requester (master modport) and a completer (slave modport).
interface apb_master_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output paddr,
    output pprot,
    output psel,
    output penable,
    output pwrite,
    output pwdata,
    output pstrb,
    input  pready,
    input  prdata,
    input  pslverr
  );

  modport slave (
    input  paddr,
    input  pprot,
    input  psel,
    input  penable,
    input  pwrite,
    input  pwdata,
    input  pstrb,
    output pready,
    output prdata,
    output pslverr
  );

endinterface

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB4 requester: one SETUP/ACCESS transfer per accepted request.
// Define APB_MASTER_CTRL_TIMEOUT_EN to enable the bounded-wait ACCESS timeout and abort path.
module apb_master_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  // request channel
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  input  logic [2:0]              req_prot,
  // response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  // APB master port
  apb_master_ctrl_if.master       apb_if
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam bit ParamsOk = (TIMEOUT_CYCLES >= 2) && ((DATA_WIDTH % 8) == 0);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  if (!ParamsOk) begin : g_bad_params
    $error("apb_master_ctrl: TIMEOUT_CYCLES must be >= 2 and DATA_WIDTH a multiple of 8");
  end

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [StrbW-1:0]      strb_q;
  logic [2:0]            prot_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  accept;
  logic                  abort;

  assign accept = req_valid && (state_q == StIdle);

`ifdef APB_MASTER_CTRL_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q;
  logic            cnt_last;

  assign cnt_last = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign abort    = (state_q == StAccess) && !apb_if.pready && cnt_last;

  // Counter clears in SETUP and stops at the last allowed ACCESS cycle, so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StSetup) begin
      cnt_d = '0;
    end else if ((state_q == StAccess) && !apb_if.pready && !cnt_last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == StAccess) begin
        if (apb_if.pready) begin
          timeout_q <= 1'b0;
        end else if (abort) begin
          timeout_q <= 1'b1;
        end
      end
    end
  end

  assign rsp_timeout = timeout_q;
`else
  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (apb_if.pready || abort) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are sampled only at the handshake and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      write_q <= req_write;
      wdata_q <= req_wdata;
      strb_q  <= req_write ? req_strb : '0;
      prot_q  <= req_prot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == StAccess) begin
      if (apb_if.pready) begin
        rdata_q <= write_q ? '0 : apb_if.prdata;
        err_q   <= apb_if.pslverr;
      end else if (abort) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Gate with rst so the request channel reads not-ready while reset is held.
  assign req_ready = (state_q == StIdle) && !rst;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign apb_if.psel    = (state_q == StSetup) || (state_q == StAccess);
  assign apb_if.penable = (state_q == StAccess);
  assign apb_if.paddr   = addr_q;
  assign apb_if.pprot   = prot_q;
  assign apb_if.pwrite  = write_q;
  assign apb_if.pwdata  = wdata_q;
  assign apb_if.pstrb   = strb_q;

endmodule
